puf_challenge_controller: RTL
=============================

Name: puf_challenge_controller

Overview:
- Initiator side of the RO-PUF counter group. It issues challenge pairs (Cha0/Cha1) and releases the counter-group reset for a fixed evaluation window.
- It samples the synchronised Response bit after each window and assembles RESP_BITS bits into one response word.
- The word is returned to the host over a valid/ready handshake. Challenges come from an internal LFSR seeded per run.

Parameters:
- RESP_BITS, 16: number of evaluations per run, i.e. the response word width.
- EVAL_CYCLES, 1024: clk cycles the counters run per evaluation.
- RST_CYCLES, 4: clk cycles the counters are held in reset before each evaluation.
- SYNC_STAGES, 2: flops in the Response synchroniser (minimum 2).

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle run request; accepted only in IDLE.
- challenge_seed  in  8  LFSR seed, captured when start is accepted.
- ro_response  in  1  Response from the counter group; asynchronous to clk.
- Cha0  out  4  first RO select.
- Cha1  out  4  second RO select.
- ro_cnt_reset_n  out  1  active-low reset to the counter group.
- busy  out  1  high from start acceptance until return to IDLE.
- resp_data  out  RESP_BITS  assembled response; bit 0 = first evaluation.
- resp_valid  out  1  resp_data valid; held until resp_ready.
- resp_ready  in  1  host accepts resp_data.

Behaviour:
- Reset, synchronous and active-high, produces: state IDLE, Cha0=0, Cha1=0, ro_cnt_reset_n=0, busy=0, resp_data=0, resp_valid=0, LFSR=8'h01, and all counters and synchroniser flops cleared.
- A reset asserted mid-run aborts the run: no partial word is output and there is no valid pulse.
- ro_cnt_reset_n is 0 in every state except RUN and SAMPLE.
- LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1, shifting left with the feedback bit entering at bit 0. A seed of 0 is replaced by 8'h01.
- Challenge derivation: Cha0 = lfsr[3:0] and Cha1 = lfsr[7:4]. If they are equal, Cha1 = lfsr[3:0] ^ 4'b1000, so Cha0 is never equal to Cha1.
- IDLE:
  - If start=1, capture the seed, clear resp_data and the bit index, set busy=1, and go to LOAD.
  - start asserted in any other state is ignored.
- LOAD (1 cycle): register Cha0/Cha1 from the current LFSR value, then go to SETTLE.
- SETTLE (RST_CYCLES cycles): ro_cnt_reset_n=0, then go to RUN.
- RUN (EVAL_CYCLES cycles): ro_cnt_reset_n=1; Cha0/Cha1 are stable.
- SAMPLE (SYNC_STAGES cycles):
  - ro_cnt_reset_n stays 1 and Cha is held.
  - On the last cycle, write the synchronised response into resp_data[bit_idx], increment bit_idx, and advance the LFSR by one step.
  - If bit_idx was RESP_BITS-1, go to DONE; otherwise go to LOAD.
- DONE: resp_valid=1 and busy=1. When resp_valid && resp_ready, the next cycle is IDLE with resp_valid=0 and busy=0.
- resp_data holds its value until the next accepted start.
- Timing per bit is 1+RST_CYCLES+EVAL_CYCLES+SYNC_STAGES cycles, which is 1031 with defaults.
- resp_valid rises exactly RESP_BITS*(per-bit time) cycles after the start-accept edge: 16496 cycles with defaults.
- Counter widths: the cycle counter is sized by clog2(max(EVAL_CYCLES, RST_CYCLES, SYNC_STAGES)); the bit index is sized by clog2(RESP_BITS+1). Neither wraps within a run.
- ro_response is only ever used through the synchroniser; there is no combinational path from it to any output.

Decomposition:
- Shared package puf_pkg contains:
  - the state enum (IDLE, LOAD, SETTLE, RUN, SAMPLE, DONE);
  - the LFSR tap mask 8'hB8 and the zero-seed substitute 8'h01;
  - the Cha-collision XOR mask 4'b1000.
- One sub-module, puf_lfsr8, with inputs load, seed, and step, and an 8-bit output state. It applies the zero-seed substitution on load.
- The synchroniser is inline.

Test Plan:
- Reset/idle: assert reset for 3 cycles -> all outputs match the reset values above; start=0 for 100 cycles -> state stays IDLE, busy=0.
- Constant response: seed 8'h01, ro_response held 1 -> resp_valid rises 16496 cycles after start acceptance, resp_data=16'hFFFF. The first Cha0/Cha1 pair is 4'h1/4'h0.
- Alternating response: drive ro_response = ~bit_idx[0] during each RUN -> resp_data=16'h5555. The Cha sequence matches the reference LFSR model for all 16 evaluations; Cha0 is never equal to Cha1.
- Seed edge cases:
  - seed 8'h00 -> identical Cha sequence and resp_data to seed 8'h01.
  - seed 8'h33 -> first Cha0=4'h3, Cha1=4'hB.
- Backpressure and re-start: hold resp_ready=0 for 10 cycles in DONE -> resp_valid and resp_data stay stable. Pulse start during RUN -> ignored, bit count unchanged.
- Mid-run reset: assert reset in RUN of bit 5 -> next cycle is IDLE with busy=0, ro_cnt_reset_n=0, resp_valid=0. A following start produces a full 16-bit run.

Source files
------------

// File: rtl/puf_pkg.sv
// Shared definitions for the RO-PUF challenge controller: FSM states,
// LFSR constants and the challenge collision mask.
package puf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    RUN,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [7:0] LFSR_TAPS     = 8'hB8;
  localparam logic [7:0] LFSR_ZERO_SUB = 8'h01;
  localparam logic [3:0] CHA_XOR       = 4'b1000;

  // Fibonacci step for x^8+x^6+x^5+x^4+1, shifting left, feedback into bit 0
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/puf_challenge_controller_lfsr.sv
// 8-bit challenge LFSR; a zero seed would lock up, so it is swapped for 8'h01.
module puf_lfsr8
  import puf_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       step,
  output logic [7:0] state
);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LFSR_ZERO_SUB;
    end else if (load) begin
      state <= (seed == 8'h00) ? LFSR_ZERO_SUB : seed;
    end else if (step) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/puf_challenge_controller.sv
// Initiator for the RO-PUF counter group: issues challenge pairs, times each
// evaluation window and assembles the sampled response bits into one word.
module puf_challenge_controller
  import puf_pkg::*;
#(
  parameter int RESP_BITS   = 16,
  parameter int EVAL_CYCLES = 1024,
  parameter int RST_CYCLES  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [7:0]           challenge_seed,
  input  logic                 ro_response,
  output logic [3:0]           Cha0,
  output logic [3:0]           Cha1,
  output logic                 ro_cnt_reset_n,
  output logic                 busy,
  output logic [RESP_BITS-1:0] resp_data,
  output logic                 resp_valid,
  input  logic                 resp_ready
);

  localparam int MAX_A   = (EVAL_CYCLES > RST_CYCLES) ? EVAL_CYCLES : RST_CYCLES;
  localparam int MAX_CYC = (MAX_A > SYNC_STAGES) ? MAX_A : SYNC_STAGES;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int IDX_W   = $clog2(RESP_BITS + 1);
  localparam int SEL_W   = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LAST    = CNT_W'(EVAL_CYCLES - 1);
  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SYNC_STAGES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(RESP_BITS - 1);

  state_t                 state;
  state_t                 state_next;
  logic [CNT_W-1:0]       cnt;
  logic [IDX_W-1:0]       bit_idx;
  logic [SYNC_STAGES-1:0] sync;
  logic [7:0]             lfsr_state;
  logic                   lfsr_load;
  logic                   lfsr_step;
  logic [3:0]             cha0_d;
  logic [3:0]             cha1_d;
  logic                   sample_last;

  puf_lfsr8 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (lfsr_load),
    .seed  (challenge_seed),
    .step  (lfsr_step),
    .state (lfsr_state)
  );

  // Equal nibbles would compare an RO against itself, so flip Cha1's MSB
  assign cha0_d = lfsr_state[3:0];
  assign cha1_d = (lfsr_state[7:4] == lfsr_state[3:0]) ? (lfsr_state[3:0] ^ CHA_XOR)
                                                       : lfsr_state[7:4];

  assign sample_last    = (state == SAMPLE) && (cnt == SAMPLE_LAST);
  assign ro_cnt_reset_n = (state == RUN) || (state == SAMPLE);
  assign busy           = (state != IDLE);
  assign resp_valid     = (state == DONE);

  always_comb begin
    state_next = state;
    lfsr_load  = 1'b0;
    lfsr_step  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          lfsr_load  = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD:   state_next = SETTLE;
      SETTLE: if (cnt == SETTLE_LAST) state_next = RUN;
      RUN:    if (cnt == RUN_LAST) state_next = SAMPLE;
      SAMPLE: begin
        if (sample_last) begin
          lfsr_step  = 1'b1;
          state_next = (bit_idx == IDX_LAST) ? DONE : LOAD;
        end
      end
      DONE:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      resp_data <= '0;
      Cha0      <= 4'h0;
      Cha1      <= 4'h0;
    end else begin
      state <= state_next;
      if ((state_next != state) || (state == IDLE) || (state == DONE)) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      if ((state == IDLE) && start) begin
        resp_data <= '0;
        bit_idx   <= '0;
      end
      if (state == LOAD) begin
        Cha0 <= cha0_d;
        Cha1 <= cha1_d;
      end
      if (sample_last) begin
        resp_data[bit_idx[SEL_W-1:0]] <= sync[SYNC_STAGES-1];
        bit_idx                       <= bit_idx + IDX_W'(1);
      end
    end
  end

  // ro_response is asynchronous; only the last synchroniser flop is ever read
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], ro_response};
    end
  end

endmodule
